usb2_ep_in_sched: RTL and testbench

- Sequences an IN endpoint's double-buffered packet RAM from a byte-stream producer.
- Waits for a free buffer, writes bytes at incrementing addresses, and commits a packet when it is full, when the producer marks a last byte, on flush, or on an idle timeout.
- Runs the commit/commit-ack four-phase handshake toward the endpoint buffer block.
- Sits between application stream logic (TS/CI data) and the USB 2.0 endpoint buffer, in the phy_clk domain.

---
 rtl/usb2_ep_in_sched_if.sv | 32 +++
 rtl/usb2_ep_in_sched.sv | 175 +++++++++++++++++
 tb/tb_usb2_ep_in_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ep_in_sched_if.sv
// rtl/usb2_ep_in_sched_if.sv - stream and endpoint-buffer signals of usb2_ep_in_sched
// master: the scheduler side (accepts the byte stream, drives the endpoint buffer); slave: its surroundings.
interface usb2_ep_in_sched_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;

    logic [10:0] buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;

    modport master (
        input  s_data, s_valid, s_last,
        output s_ready,
        output buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_commit, buf_in_commit_len,
        input  buf_in_ready, buf_in_commit_ack
    );

    modport slave (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_commit, buf_in_commit_len,
        output buf_in_ready, buf_in_commit_ack
    );
endinterface

// File: rtl/usb2_ep_in_sched.sv
// rtl/usb2_ep_in_sched.sv - IN endpoint packet scheduler over a double-buffered packet RAM
// Define USB2_EP_IN_SCHED_ZLP_EN to follow a full-size s_last packet with a zero-length packet.
module usb2_ep_in_sched #(
    parameter int MAX_PKT = 512,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic               phy_clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   pkt_count_o,
    usb2_ep_in_sched_if.master bus
);
    localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [10:0]      MAX_LEN  = 11'(MAX_PKT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT, S_ACK_LOW} state_e;

    state_e           state_q, state_d;
    logic [10:0]      count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [10:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             wren_q, wren_d;
    logic             commit_q, commit_d;
    logic [10:0]      len_q, len_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic        s_ready_w;
    logic        accept;
    logic [10:0] post_count;
    logic        full_hit;
    logic        tmo_hit;
    logic        commit_req;
    logic        zlp_pend;

    assign s_ready_w  = (state_q == S_FILL) && (count_q < MAX_LEN) && !abort_i;
    assign accept     = bus.s_valid && s_ready_w;
    assign post_count = count_q + 11'(accept);
    assign full_hit   = accept && (post_count == MAX_LEN);
    // A timeout only fires on an idle cycle, so a byte arriving on the deadline still joins the packet.
    assign tmo_hit    = TMO_EN && (count_q != 11'd0) && (timer_q == TMR_LAST) && !accept;
    assign commit_req = !abort_i && ((accept && (full_hit || bus.s_last))
                                     || (flush_i && (post_count != 11'd0))
                                     || tmo_hit);

`ifdef USB2_EP_IN_SCHED_ZLP_EN
    logic zlp_q, zlp_d;

    always_comb begin
        zlp_d = zlp_q;
        if (commit_req && accept && bus.s_last && (post_count == MAX_LEN)) begin
            zlp_d = 1'b1;
        end else if ((state_q == S_IDLE) && bus.buf_in_ready) begin
            zlp_d = 1'b0;
        end
    end

    always_ff @(posedge phy_clk_i) begin
        if (reset_i) begin
            zlp_q <= 1'b0;
        end else begin
            zlp_q <= zlp_d;
        end
    end

    assign zlp_pend = zlp_q;
`else
    assign zlp_pend = 1'b0;
`endif

    always_ff @(posedge phy_clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            timer_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            commit_q  <= 1'b0;
            len_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            commit_q  <= commit_d;
            len_q     <= len_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.buf_in_ready) begin
                    state_d = zlp_pend ? S_COMMIT : S_FILL;
                end
            end
            S_FILL: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (commit_req) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (bus.buf_in_commit_ack) begin
                    state_d = S_ACK_LOW;
                end
            end
            S_ACK_LOW: begin
                if (!bus.buf_in_commit_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // commit is registered off the COMMIT state, so it trails the last write strobe by one cycle.
    always_comb begin
        count_d   = count_q;
        timer_d   = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = accept;
        len_d     = len_q;
        commit_d  = (state_q == S_COMMIT) && !bus.buf_in_commit_ack;
        pkt_cnt_d = pkt_cnt_q;

        if (accept) begin
            count_d = post_count;
            addr_d  = count_q;
            data_d  = bus.s_data;
        end

        if (state_q == S_FILL) begin
            if (abort_i) begin
                count_d = '0;
            end else if (commit_req) begin
                len_d = post_count;
            end
            if (!accept && (count_q != 11'd0)) begin
                timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
            end
        end

        if ((state_q == S_IDLE) && bus.buf_in_ready && zlp_pend) begin
            len_d = '0;
        end

        if ((state_q == S_COMMIT) && bus.buf_in_commit_ack) begin
            count_d   = '0;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    assign bus.s_ready           = s_ready_w;
    assign bus.buf_in_addr       = addr_q;
    assign bus.buf_in_data       = data_q;
    assign bus.buf_in_wren       = wren_q;
    assign bus.buf_in_commit     = commit_q;
    assign bus.buf_in_commit_len = len_q;
    assign busy_o                = (state_q != S_IDLE);
    assign pkt_count_o           = pkt_cnt_q;
endmodule

// File: tb/tb_usb2_ep_in_sched.sv
// tb/tb_usb2_ep_in_sched.sv - self-checking bench for usb2_ep_in_sched
module tb_usb2_ep_in_sched;
    localparam int MAX_PKT = 512;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
`ifdef USB2_EP_IN_SCHED_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] pkt_count;

    usb2_ep_in_sched_if bus ();

    usb2_ep_in_sched #(.MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .phy_clk_i  (clk),
        .reset_i    (rst),
        .flush_i    (flush),
        .abort_i    (abort),
        .busy_o     (busy),
        .pkt_count_o(pkt_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: packets as byte lists, closed by the spec's commit rules.
    int           exp_len_q[$];
    bit           exp_tight_q[$];
    byte unsigned exp_byte_q[$];
    byte unsigned acc_q[$];
    int           exp_commits = 0;
    int           commits_seen = 0;
    int           last_acc_cyc = 0;
    int           last_commit_cyc = 0;
    bit           ep_active = 1'b0;

    task automatic push_pkt(input int len, input bit tight);
        exp_len_q.push_back(len);
        exp_tight_q.push_back(tight);
        exp_commits++;
    endtask

    task automatic close_pkt(input bit was_last);
        int len;
        len = acc_q.size();
        foreach (acc_q[i]) exp_byte_q.push_back(acc_q[i]);
        push_pkt(len, 1'b1);
        if (ZLP && was_last && len == MAX_PKT) push_pkt(0, 1'b0);
        acc_q.delete();
    endtask

    // Monitor on the endpoint side of the block.
    byte unsigned wr_buf [0:1023];
    int           wr_idx = 0;
    logic         commit_prev = 1'b0, ack_prev = 1'b0, wren_prev = 1'b0;
    int           m_len, m_bad;
    bit           m_tight;
    byte unsigned m_e;

    always @(negedge clk) begin
        if (rst) begin
            wr_idx = 0;
        end else begin
            if (bus.buf_in_wren) begin
                check("wr_addr", int'(bus.buf_in_addr), wr_idx);
                if (wr_idx < 1024) wr_buf[wr_idx] = bus.buf_in_data;
                wr_idx++;
            end
            if (abort) wr_idx = 0;
            if (bus.buf_in_commit && !commit_prev) begin
                commits_seen++;
                last_commit_cyc = cyc;
                if (exp_len_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got len %0d, expected no commit", bus.buf_in_commit_len);
                end else begin
                    m_len   = exp_len_q.pop_front();
                    m_tight = exp_tight_q.pop_front();
                    check("commit_len", int'(bus.buf_in_commit_len), m_len);
                    check("write_count", wr_idx, m_len);
                    m_bad = 0;
                    for (int i = 0; i < m_len; i++) begin
                        m_e = exp_byte_q.pop_front();
                        if (i >= wr_idx || wr_buf[i] != m_e) m_bad++;
                    end
                    check("commit_data_errors", m_bad, 0);
                    if (m_tight) check("commit_after_wren", int'(wren_prev), 1);
                end
                wr_idx = 0;
            end
            if (!bus.buf_in_commit && commit_prev) begin
                check("commit_drop_on_ack", int'(ack_prev), 1);
                check("pkt_count", int'(pkt_count), commits_seen % (1 << CNT_W));
            end
        end
        commit_prev = bus.buf_in_commit;
        ack_prev    = bus.buf_in_commit_ack;
        wren_prev   = bus.buf_in_wren;
    end

    // Endpoint buffer: acks each commit after a random delay, holding ack 4..6 cycles.
    initial begin
        bus.buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.buf_in_commit && !ep_active) begin
                ep_active = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 bus.buf_in_commit_ack = 1'b1;
                repeat ($urandom_range(4, 6)) @(posedge clk);
                #1 bus.buf_in_commit_ack = 1'b0;
                ep_active = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte unsigned d, input bit last, input bit fl, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        bus.s_data  = d;
        bus.s_last  = last;
        flush       = fl;
        bus.s_valid = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        check("s_ready_wait", int'(ok), 1);
        if (ok) last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        flush       = 1'b0;
        if (ok) acc_q.push_back(d);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_len_q.size() == 0 && !bus.buf_in_commit && !bus.buf_in_commit_ack && !ep_active)
                   && n < 3000);
        check("drain_in_time", int'(n < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int nbytes;
        bit last;
        bit fl;
        bit ab;
        int idle;
        int exp_len;
        bit tight;
        bit zlp;
    } vec_t;

    vec_t vecs [0:8];
    bit   lst, fl, ok;
    int   r, t0, nw;

    initial begin
        rst = 1'b1; flush = 1'b0; abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0; bus.buf_in_ready = 1'b0;

        vecs[0] = '{512, 1'b0, 1'b0, 1'b0,   2, 512, 1'b1, 1'b0};
        vecs[1] = '{  3, 1'b1, 1'b0, 1'b0,   2,   3, 1'b1, 1'b0};
        vecs[2] = '{  5, 1'b0, 1'b0, 1'b0,  30,   5, 1'b0, 1'b0};
        vecs[3] = '{  0, 1'b0, 1'b1, 1'b0, 100,  -1, 1'b0, 1'b0};
        vecs[4] = '{ 10, 1'b0, 1'b0, 1'b1,   2,  -1, 1'b0, 1'b0};
        vecs[5] = '{  4, 1'b1, 1'b0, 1'b0,   2,   4, 1'b1, 1'b0};
        vecs[6] = '{  7, 1'b0, 1'b1, 1'b0,   2,   7, 1'b1, 1'b0};
        vecs[7] = '{512, 1'b1, 1'b0, 1'b0,   2, 512, 1'b1, 1'b1};
        vecs[8] = '{  1, 1'b0, 1'b1, 1'b0,   2,   1, 1'b1, 1'b0};

        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_wren", int'(bus.buf_in_wren), 0);
        check("rst_addr", int'(bus.buf_in_addr), 0);
        check("rst_commit", int'(bus.buf_in_commit), 0);
        check("rst_commit_len", int'(bus.buf_in_commit_len), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pkt_count", int'(pkt_count), 0);

        // Back-pressure: endpoint full, producer waiting with a one-byte transfer.
        bus.s_valid = 1'b1; bus.s_last = 1'b1; bus.s_data = 8'hA5;
        nw = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready || bus.buf_in_wren) nw++;
        end
        check("bp_no_ready_no_wren", nw, 0);
        exp_byte_q.push_back(8'hA5);
        push_pkt(1, 1'b1);
        step(1);
        bus.buf_in_ready = 1'b1;
        t0 = cyc;
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (!bus.buf_in_wren && nw < 10);
        check("bp_first_wren_latency", cyc - t0, 2);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        wait_drain();

        for (int v = 0; v < 9; v++) begin
            step(1);
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                lst = vecs[v].last && (i == vecs[v].nbytes - 1);
                fl  = vecs[v].fl && (i == vecs[v].nbytes - 1);
                send_byte(8'(i), lst, fl, ok);
            end
            if (vecs[v].ab) begin
                abort = 1'b1;
                @(negedge clk);
                check("abort_blocks_ready", int'(bus.s_ready), 0);
                step(1);
                abort = 1'b0;
            end
            acc_q.delete();
            if (vecs[v].exp_len >= 0) begin
                for (int i = 0; i < vecs[v].exp_len; i++) exp_byte_q.push_back(8'(i));
                push_pkt(vecs[v].exp_len, vecs[v].tight);
                if (ZLP && vecs[v].zlp) push_pkt(0, 1'b0);
            end
            if (vecs[v].nbytes == 0) flush = vecs[v].fl;
            step(vecs[v].idle);
            flush = 1'b0;
            wait_drain();
            check("vec_commit_total", commits_seen, exp_commits);
            if (!vecs[v].tight && vecs[v].exp_len > 0)
                check("timeout_latency", last_commit_cyc - last_acc_cyc, TIMEOUT + 2);
        end

        step(1);
        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2 && acc_q.size() > 0) begin
                abort = 1'b1;
                step(1);
                abort = 1'b0;
                acc_q.delete();
            end else if (r < 5 && acc_q.size() == 0) begin
                bus.buf_in_ready = 1'b0;
                step(int'($urandom_range(1, 12)));
                bus.buf_in_ready = 1'b1;
            end else if (r < 25) begin
                step(int'($urandom_range(1, 3)));
            end
            lst = ($urandom_range(0, 99) < 4);
            fl  = !lst && ($urandom_range(0, 99) < 2);
            send_byte(8'($urandom_range(0, 255)), lst, fl, ok);
            if (ok && (acc_q.size() == MAX_PKT || lst || fl)) close_pkt(lst);
        end
        if (acc_q.size() > 0) begin
            send_byte(8'h5A, 1'b1, 1'b0, ok);
            if (ok) close_pkt(1'b1);
        end
        wait_drain();
        check("rand_commit_total", commits_seen, exp_commits);
        check("final_pkt_count", int'(pkt_count), exp_commits % (1 << CNT_W));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
